// File: rtl/superh16_pkg.sv
// Shared SuperH16 load/store parameters, the store-queue entry record and the byte-mask helper.
package superh16_pkg;

    localparam int XLEN         = 64;
    localparam int VADDR_WIDTH  = 48;
    localparam int ROB_IDX_BITS = 7;
    localparam int SQ_DEPTH     = 16;
    localparam int SQ_IDX_BITS  = $clog2(SQ_DEPTH);

    typedef struct packed {
        logic                    valid;
        logic                    addr_valid;
        logic                    committed;
        logic [ROB_IDX_BITS-1:0] rob_idx;
        logic [VADDR_WIDTH-1:0]  addr;
        logic [2:0]              size;
        logic [7:0]              mask;
        logic [XLEN-1:0]         data;
    } sq_entry_t;

    // Byte-enable mask within the 8-byte line; sizes above D saturate to all bytes.
    function automatic logic [7:0] size_to_mask(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/superh16_sq_fwd_select.sv
// Store-to-load forwarding search: youngest overlapping older store wins, then bytes are realigned.
module superh16_sq_fwd_select
    import superh16_pkg::*;
(
    input  sq_entry_t                entries_i [SQ_DEPTH],
    input  logic [SQ_IDX_BITS:0]     head_i,
    input  logic                     probe_valid_i,
    input  logic [VADDR_WIDTH-1:0]   probe_addr_i,
    input  logic [2:0]               probe_size_i,
    input  logic [SQ_IDX_BITS:0]     probe_tail_i,
    output logic                     fwd_valid_o,
    output logic                     fwd_stall_o,
    output logic [XLEN-1:0]          fwd_data_o
);

    localparam int PTR_W = SQ_IDX_BITS + 1;

    logic [7:0]             ldMask;
    logic [PTR_W-1:0]       span;
    logic                   spanOk;
    logic                   hit;
    logic [SQ_IDX_BITS-1:0] hitIdx;
    logic [SQ_IDX_BITS-1:0] idx;
    sq_entry_t              hitEntry;
    logic                   unused_fields;

    assign ldMask = size_to_mask(probe_size_i, probe_addr_i[2:0]);
    // A snapshot the head has already passed wraps to a span above the depth: nothing older remains.
    assign span   = probe_tail_i - head_i;
    assign spanOk = span <= PTR_W'(SQ_DEPTH);

    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        idx    = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            idx = head_i[SQ_IDX_BITS-1:0] + SQ_IDX_BITS'(i);
            if (spanOk && (PTR_W'(i) < span) &&
                entries_i[idx].valid && entries_i[idx].addr_valid &&
                (entries_i[idx].addr[VADDR_WIDTH-1:3] == probe_addr_i[VADDR_WIDTH-1:3]) &&
                ((entries_i[idx].mask & ldMask) != 8'h00)) begin
                hit    = 1'b1;
                hitIdx = idx;
            end
        end
    end

    always_comb begin
        fwd_valid_o = 1'b0;
        fwd_stall_o = 1'b0;
        fwd_data_o  = '0;
        hitEntry    = entries_i[hitIdx];
        if (probe_valid_i && hit) begin
            if ((hitEntry.mask & ldMask) == ldMask) begin
                fwd_valid_o = 1'b1;
                fwd_data_o  = (hitEntry.data << {hitEntry.addr[2:0], 3'b000}) >> {probe_addr_i[2:0], 3'b000};
            end else begin
                fwd_stall_o = 1'b1;
            end
        end
    end

    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            unused_fields = unused_fields ^ (^{entries_i[i].committed, entries_i[i].rob_idx, entries_i[i].size});
        end
    end

endmodule

// File: rtl/superh16_store_queue.sv
// Circular store queue: holds stores from dispatch to D-cache write, forwards to younger loads,
// and drains committed stores in program order.
module superh16_store_queue
    import superh16_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_valid_i,
    input  logic [ROB_IDX_BITS-1:0]  alloc_rob_idx_i,
    output logic                     alloc_ready_o,
    output logic [SQ_IDX_BITS:0]     alloc_sq_idx_o,
    input  logic                     exec_valid_i,
    input  logic [SQ_IDX_BITS-1:0]   exec_sq_idx_i,
    input  logic [VADDR_WIDTH-1:0]   exec_addr_i,
    input  logic [2:0]               exec_size_i,
    input  logic [XLEN-1:0]          exec_data_i,
    input  logic                     commit_valid_i,
    input  logic                     flush_valid_i,
    input  logic                     lq_probe_valid_i,
    input  logic [VADDR_WIDTH-1:0]   lq_probe_addr_i,
    input  logic [2:0]               lq_probe_size_i,
    input  logic [SQ_IDX_BITS:0]     lq_probe_sq_tail_i,
    output logic                     sq_forward_valid_o,
    output logic [XLEN-1:0]          sq_forward_data_o,
    output logic                     sq_forward_stall_o,
    output logic                     dcache_st_req_o,
    output logic [VADDR_WIDTH-1:0]   dcache_st_addr_o,
    output logic [2:0]               dcache_st_size_o,
    output logic [XLEN-1:0]          dcache_st_data_o,
    input  logic                     dcache_st_ack_i,
    output logic                     empty_o
);

    localparam int PTR_W = SQ_IDX_BITS + 1;

    sq_entry_t              entries_q [SQ_DEPTH];
    sq_entry_t              entries_d [SQ_DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       commit_q, commit_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [PTR_W-1:0]       flushSpan;
    logic [SQ_IDX_BITS-1:0] flushIdx;
    logic [SQ_IDX_BITS-1:0] headIdx, commitIdx, tailIdx;
    logic                   full, allocFire, drainFire;

    assign headIdx   = head_q[SQ_IDX_BITS-1:0];
    assign commitIdx = commit_q[SQ_IDX_BITS-1:0];
    assign tailIdx   = tail_q[SQ_IDX_BITS-1:0];

    assign full           = (tail_q - head_q) == PTR_W'(SQ_DEPTH);
    assign alloc_ready_o  = !full && !flush_valid_i;
    assign alloc_sq_idx_o = tail_q;
    assign allocFire      = alloc_valid_i && alloc_ready_o;
    assign empty_o        = tail_q == head_q;

    assign dcache_st_req_o  = head_q != commit_q;
    assign dcache_st_addr_o = entries_q[headIdx].addr;
    assign dcache_st_size_o = entries_q[headIdx].size;
    assign dcache_st_data_o = entries_q[headIdx].data;
    assign drainFire        = dcache_st_req_o && dcache_st_ack_i;

    // Flush squashes everything younger than the post-commit pointer; committed stores survive.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q + PTR_W'(drainFire);
        commit_d  = commit_q + PTR_W'(commit_valid_i);
        tail_d    = tail_q + PTR_W'(allocFire);
        flushSpan = '0;
        flushIdx  = '0;
        if (exec_valid_i && !flush_valid_i && entries_q[exec_sq_idx_i].valid) begin
            entries_d[exec_sq_idx_i].addr       = exec_addr_i;
            entries_d[exec_sq_idx_i].size       = exec_size_i;
            entries_d[exec_sq_idx_i].data       = exec_data_i;
            entries_d[exec_sq_idx_i].mask       = size_to_mask(exec_size_i, exec_addr_i[2:0]);
            entries_d[exec_sq_idx_i].addr_valid = 1'b1;
        end
        if (allocFire) begin
            entries_d[tailIdx].valid      = 1'b1;
            entries_d[tailIdx].addr_valid = 1'b0;
            entries_d[tailIdx].committed  = 1'b0;
            entries_d[tailIdx].rob_idx    = alloc_rob_idx_i;
        end
        if (commit_valid_i) begin
            entries_d[commitIdx].committed = 1'b1;
        end
        if (drainFire) begin
            entries_d[headIdx].valid = 1'b0;
        end
        if (flush_valid_i) begin
            tail_d    = commit_d;
            flushSpan = tail_q - commit_d;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (PTR_W'(i) < flushSpan) begin
                    flushIdx                       = commit_d[SQ_IDX_BITS-1:0] + SQ_IDX_BITS'(i);
                    entries_d[flushIdx].valid      = 1'b0;
                    entries_d[flushIdx].addr_valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // The probe looks at registered entries only, so a same-cycle exec is invisible to it.
    superh16_sq_fwd_select u_fwd_select (
        .entries_i     (entries_q),
        .head_i        (head_q),
        .probe_valid_i (lq_probe_valid_i),
        .probe_addr_i  (lq_probe_addr_i),
        .probe_size_i  (lq_probe_size_i),
        .probe_tail_i  (lq_probe_sq_tail_i),
        .fwd_valid_o   (sq_forward_valid_o),
        .fwd_stall_o   (sq_forward_stall_o),
        .fwd_data_o    (sq_forward_data_o)
    );

    function automatic logic crossesLine(input logic [2:0] off, input logic [2:0] size);
        return (size > 3'd3) || (({2'b00, off} + (5'd1 << size)) > 5'd8);
    endfunction

    commitOrdered: assert property (@(posedge clk) disable iff (!rst_n)
        commit_valid_i |-> (commit_q != tail_q) && entries_q[commitIdx].valid && entries_q[commitIdx].addr_valid);
    execAligned: assert property (@(posedge clk) disable iff (!rst_n)
        exec_valid_i |-> !crossesLine(exec_addr_i[2:0], exec_size_i));
    probeAligned: assert property (@(posedge clk) disable iff (!rst_n)
        lq_probe_valid_i |-> !crossesLine(lq_probe_addr_i[2:0], lq_probe_size_i));

endmodule

// File: tb/tb_superh16_store_queue.sv
// Self-checking bench for superh16_store_queue: forwarding vector table plus drain scoreboard.
module tb_superh16_store_queue;
    import superh16_pkg::*;

    localparam int PTR_W = SQ_IDX_BITS + 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    alloc_valid_i;
    logic [ROB_IDX_BITS-1:0] alloc_rob_idx_i;
    logic                    alloc_ready_o;
    logic [PTR_W-1:0]        alloc_sq_idx_o;
    logic                    exec_valid_i;
    logic [SQ_IDX_BITS-1:0]  exec_sq_idx_i;
    logic [VADDR_WIDTH-1:0]  exec_addr_i;
    logic [2:0]              exec_size_i;
    logic [XLEN-1:0]         exec_data_i;
    logic                    commit_valid_i;
    logic                    flush_valid_i;
    logic                    lq_probe_valid_i;
    logic [VADDR_WIDTH-1:0]  lq_probe_addr_i;
    logic [2:0]              lq_probe_size_i;
    logic [PTR_W-1:0]        lq_probe_sq_tail_i;
    logic                    sq_forward_valid_o;
    logic [XLEN-1:0]         sq_forward_data_o;
    logic                    sq_forward_stall_o;
    logic                    dcache_st_req_o;
    logic [VADDR_WIDTH-1:0]  dcache_st_addr_o;
    logic [2:0]              dcache_st_size_o;
    logic [XLEN-1:0]         dcache_st_data_o;
    logic                    dcache_st_ack_i;
    logic                    empty_o;

    always #5 clk = ~clk;

    superh16_store_queue dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_rob_idx_i    (alloc_rob_idx_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_sq_idx_o     (alloc_sq_idx_o),
        .exec_valid_i       (exec_valid_i),
        .exec_sq_idx_i      (exec_sq_idx_i),
        .exec_addr_i        (exec_addr_i),
        .exec_size_i        (exec_size_i),
        .exec_data_i        (exec_data_i),
        .commit_valid_i     (commit_valid_i),
        .flush_valid_i      (flush_valid_i),
        .lq_probe_valid_i   (lq_probe_valid_i),
        .lq_probe_addr_i    (lq_probe_addr_i),
        .lq_probe_size_i    (lq_probe_size_i),
        .lq_probe_sq_tail_i (lq_probe_sq_tail_i),
        .sq_forward_valid_o (sq_forward_valid_o),
        .sq_forward_data_o  (sq_forward_data_o),
        .sq_forward_stall_o (sq_forward_stall_o),
        .dcache_st_req_o    (dcache_st_req_o),
        .dcache_st_addr_o   (dcache_st_addr_o),
        .dcache_st_size_o   (dcache_st_size_o),
        .dcache_st_data_o   (dcache_st_data_o),
        .dcache_st_ack_i    (dcache_st_ack_i),
        .empty_o            (empty_o)
    );

    typedef struct {
        logic [VADDR_WIDTH-1:0] addr;
        logic [2:0]             size;
        logic [XLEN-1:0]        data;
    } drain_t;

    typedef struct {
        string                  name;
        logic                   pv;
        logic [VADDR_WIDTH-1:0] addr;
        logic [2:0]             size;
        logic [PTR_W-1:0]       snap;
        logic                   expV;
        logic                   expS;
        logic [XLEN-1:0]        expData;
        logic [XLEN-1:0]        dataMask;
    } fwd_vec_t;

    drain_t   expQ[$];
    drain_t   model [SQ_DEPTH];
    drain_t   monExp;
    fwd_vec_t fwdVec [12];
    int       commitModel = 0;
    int       passCount = 0;
    int       checkCount = 0;
    int       acks;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        alloc_valid_i      = 1'b0;
        alloc_rob_idx_i    = '0;
        exec_valid_i       = 1'b0;
        exec_sq_idx_i      = '0;
        exec_addr_i        = '0;
        exec_size_i        = '0;
        exec_data_i        = '0;
        commit_valid_i     = 1'b0;
        flush_valid_i      = 1'b0;
        lq_probe_valid_i   = 1'b0;
        lq_probe_addr_i    = '0;
        lq_probe_size_i    = '0;
        lq_probe_sq_tail_i = '0;
        dcache_st_ack_i    = 1'b0;
    endtask

    task automatic resetDut();
        idleInputs();
        rst_n = 1'b0;
        expQ.delete();
        commitModel = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock of alloc/exec/commit; expected drain records are queued as commits are issued.
    task automatic applyStimulus(input logic alloc, input logic execEn, input int execIdx,
                                 input logic [VADDR_WIDTH-1:0] addr, input logic [2:0] size,
                                 input logic [XLEN-1:0] data, input logic commit);
        alloc_valid_i   = alloc;
        alloc_rob_idx_i = ROB_IDX_BITS'($urandom);
        exec_valid_i    = execEn;
        exec_sq_idx_i   = SQ_IDX_BITS'(execIdx);
        exec_addr_i     = addr;
        exec_size_i     = size;
        exec_data_i     = data;
        commit_valid_i  = commit;
        if (execEn) model[execIdx] = '{addr, size, data};
        if (commit) begin
            expQ.push_back(model[commitModel]);
            commitModel = (commitModel + 1) % SQ_DEPTH;
        end
        tick();
        idleInputs();
    endtask

    task automatic probe(input logic pv, input logic [VADDR_WIDTH-1:0] addr, input logic [2:0] size,
                         input logic [PTR_W-1:0] snap);
        lq_probe_valid_i   = pv;
        lq_probe_addr_i    = addr;
        lq_probe_size_i    = size;
        lq_probe_sq_tail_i = snap;
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && dcache_st_req_o && dcache_st_ack_i) begin
            if (expQ.size() == 0) begin
                checkOutput("drain_unexpected", 64'd1, 64'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("drain_addr", 64'(dcache_st_addr_o), 64'(monExp.addr));
                checkOutput("drain_size", 64'(dcache_st_size_o), 64'(monExp.size));
                checkOutput("drain_data", dcache_st_data_o, monExp.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        fwdVec[0]  = '{"ld_w_after_sd",   1'b1, 48'h1004, 3'd2, 5'd1, 1'b1, 1'b0, 64'h11223344,       64'hFFFF_FFFF};
        fwdVec[1]  = '{"ld_w_all_older",  1'b1, 48'h1004, 3'd2, 5'd4, 1'b1, 1'b0, 64'h11223344,       64'hFFFF_FFFF};
        fwdVec[2]  = '{"lb_youngest_sw",  1'b1, 48'h1003, 3'd0, 5'd4, 1'b1, 1'b0, 64'hDE,             64'hFF};
        fwdVec[3]  = '{"lb_from_sb",      1'b1, 48'h1003, 3'd0, 5'd2, 1'b1, 1'b0, 64'hAA,             64'hFF};
        fwdVec[4]  = '{"lb_from_sd",      1'b1, 48'h1003, 3'd0, 5'd1, 1'b1, 1'b0, 64'h55,             64'hFF};
        fwdVec[5]  = '{"lh_partial",      1'b1, 48'h2000, 3'd1, 5'd4, 1'b0, 1'b1, 64'h0,              64'h0};
        fwdVec[6]  = '{"lh_before_store", 1'b1, 48'h2000, 3'd1, 5'd3, 1'b0, 1'b0, 64'h0,              64'h0};
        fwdVec[7]  = '{"ld_partial_sw",   1'b1, 48'h1000, 3'd3, 5'd4, 1'b0, 1'b1, 64'h0,              64'h0};
        fwdVec[8]  = '{"lh_mid_sw",       1'b1, 48'h1002, 3'd1, 5'd3, 1'b1, 1'b0, 64'hDEAD,           64'hFFFF};
        fwdVec[9]  = '{"probe_idle",      1'b0, 48'h1004, 3'd2, 5'd4, 1'b0, 1'b0, 64'h0,              64'h0};
        fwdVec[10] = '{"other_line",      1'b1, 48'h3000, 3'd2, 5'd4, 1'b0, 1'b0, 64'h0,              64'h0};
        fwdVec[11] = '{"lb_skip_sb",      1'b1, 48'h1002, 3'd0, 5'd2, 1'b1, 1'b0, 64'h66,             64'hFF};

        idleInputs();
        resetDut();
        checkOutput("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
        checkOutput("rst_empty", 64'(empty_o), 64'd1);
        checkOutput("rst_alloc_idx", 64'(alloc_sq_idx_o), 64'd0);
        checkOutput("rst_fwd_valid", 64'(sq_forward_valid_o), 64'd0);
        checkOutput("rst_fwd_stall", 64'(sq_forward_stall_o), 64'd0);
        checkOutput("rst_fwd_data", sq_forward_data_o, 64'd0);
        checkOutput("rst_st_req", 64'(dcache_st_req_o), 64'd0);

        for (int i = 0; i < SQ_DEPTH; i++) begin
            checkOutput("fill_alloc_idx", 64'(alloc_sq_idx_o), 64'(i));
            applyStimulus(1'b1, 1'b0, 0, '0, '0, '0, 1'b0);
        end
        checkOutput("full_alloc_ready", 64'(alloc_ready_o), 64'd0);
        checkOutput("full_alloc_idx_wrap", 64'(alloc_sq_idx_o), 64'd16);
        applyStimulus(1'b1, 1'b0, 0, '0, '0, '0, 1'b0);
        checkOutput("full_alloc_dropped", 64'(alloc_sq_idx_o), 64'd16);
        applyStimulus(1'b0, 1'b1, 0, 48'h100, 3'd3, 64'hA5A5_0123_4567_89AB, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, '0, '0, '0, 1'b1);
        checkOutput("full_st_req", 64'(dcache_st_req_o), 64'd1);
        checkOutput("full_until_ack", 64'(alloc_ready_o), 64'd0);
        dcache_st_ack_i = 1'b1;
        tick();
        dcache_st_ack_i = 1'b0;
        checkOutput("ready_after_ack", 64'(alloc_ready_o), 64'd1);
        checkOutput("req_after_ack", 64'(dcache_st_req_o), 64'd0);

        resetDut();
        repeat (4) applyStimulus(1'b1, 1'b0, 0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 48'h1000, 3'd3, 64'h1122334455667788, 1'b0);
        applyStimulus(1'b0, 1'b1, 1, 48'h1003, 3'd0, 64'hAA, 1'b0);
        applyStimulus(1'b0, 1'b1, 2, 48'h1000, 3'd2, 64'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 1'b1, 3, 48'h2001, 3'd0, 64'h55, 1'b0);
        foreach (fwdVec[i]) begin
            probe(fwdVec[i].pv, fwdVec[i].addr, fwdVec[i].size, fwdVec[i].snap);
            checkOutput({fwdVec[i].name, "_valid"}, 64'(sq_forward_valid_o), 64'(fwdVec[i].expV));
            checkOutput({fwdVec[i].name, "_stall"}, 64'(sq_forward_stall_o), 64'(fwdVec[i].expS));
            if (fwdVec[i].expV)
                checkOutput({fwdVec[i].name, "_data"}, sq_forward_data_o & fwdVec[i].dataMask, fwdVec[i].expData);
        end
        idleInputs();

        applyStimulus(1'b1, 1'b0, 0, '0, '0, '0, 1'b0);
        exec_valid_i  = 1'b1;
        exec_sq_idx_i = SQ_IDX_BITS'(4);
        exec_addr_i   = 48'h1003;
        exec_size_i   = 3'd0;
        exec_data_i   = 64'h77;
        probe(1'b1, 48'h1003, 3'd0, 5'd5);
        checkOutput("nobypass_valid", 64'(sq_forward_valid_o), 64'd1);
        checkOutput("nobypass_data", sq_forward_data_o & 64'hFF, 64'hDE);
        tick();
        exec_valid_i = 1'b0;
        #1;
        checkOutput("after_exec_data", sq_forward_data_o & 64'hFF, 64'h77);
        idleInputs();

        resetDut();
        repeat (4) applyStimulus(1'b1, 1'b0, 0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b1, i, 48'h4000 + 48'(8 * i), 3'd3, 64'hC0DE_0000_0000_0000 | 64'(i), 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 0, '0, '0, '0, 1'b1);
        flush_valid_i = 1'b1;
        alloc_valid_i = 1'b1;
        #1;
        checkOutput("flush_alloc_ready", 64'(alloc_ready_o), 64'd0);
        tick();
        idleInputs();
        checkOutput("flush_tail", 64'(alloc_sq_idx_o), 64'd2);
        checkOutput("flush_not_empty", 64'(empty_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("stall_req", 64'(dcache_st_req_o), 64'd1);
            checkOutput("stall_addr", 64'(dcache_st_addr_o), 64'h4000);
            tick();
        end
        acks = 0;
        dcache_st_ack_i = 1'b1;
        for (int c = 0; c < 10 && dcache_st_req_o; c++) begin
            acks++;
            tick();
        end
        dcache_st_ack_i = 1'b0;
        checkOutput("drain_count", 64'(acks), 64'd2);
        checkOutput("drained_empty", 64'(empty_o), 64'd1);
        checkOutput("drained_req", 64'(dcache_st_req_o), 64'd0);
        checkOutput("scoreboard_left", 64'(expQ.size()), 64'd0);

        resetDut();
        applyStimulus(1'b1, 1'b0, 0, '0, '0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 48'h5000, 3'd3, 64'h0BAD_F00D_0BAD_F00D, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, '0, '0, '0, 1'b1);
        checkOutput("pre_reset_req", 64'(dcache_st_req_o), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req", 64'(dcache_st_req_o), 64'd0);
        checkOutput("async_rst_empty", 64'(empty_o), 64'd1);
        checkOutput("async_rst_ready", 64'(alloc_ready_o), 64'd1);
        checkOutput("async_rst_idx", 64'(alloc_sq_idx_o), 64'd0);
        resetDut();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
